// File: rtl/cacheline_adapter_if.sv
// Cache-line/burst adapter bus: cache line side and memory beat side.
// slave = adapter view, master = cache plus memory environment view.
interface cacheline_adapter_if #(
  parameter int BURST_W   = 64,
  parameter int BURST_LEN = 4
);
  logic [BURST_W*BURST_LEN-1:0] line_i;
  logic [BURST_W*BURST_LEN-1:0] line_o;
  logic [31:0]                  address_i;
  logic                         read_i;
  logic                         write_i;
  logic                         resp_o;
  logic [BURST_W-1:0]           burst_i;
  logic [BURST_W-1:0]           burst_o;
  logic [31:0]                  address_o;
  logic                         read_o;
  logic                         write_o;
  logic                         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i,
    input  burst_i, resp_i,
    output line_o, resp_o,
    output burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i,
    output burst_i, resp_i,
    input  line_o, resp_o,
    input  burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cache line reads/writes into BURST_LEN memory beats of BURST_W.
// Ports: clk, rst (async active-low), bus (cacheline_adapter_if.slave).
// CACHELINE_ADAPTER_EARLY_RESP_EN: resp_o on the final beat, no DONE state.
module cacheline_adapter #(
  parameter int BURST_W   = 64,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);
  localparam int LW = BURST_W * BURST_LEN;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OB = $clog2(LW / 8);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [31:0] AMASK = ~((32'd1 << OB) - 32'd1);

`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam state_t FIN = IDLE;
`else
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam state_t FIN = DONE;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   wbuf_q, wbuf_d;
  logic [LW-1:0]   line_q, line_d;
  logic            last_beat;

  assign last_beat = bus.resp_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (bus.write_i || bus.read_i) begin
          // write wins when both requests are present
          state_d = bus.write_i ? WRITE : READ;
          addr_d  = bus.address_i & AMASK;
          wbuf_d  = bus.line_i;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          for (int i = 0; i < BURST_LEN; i++) begin
            if (cnt_q == CW'(i)) begin
              line_d[i*BURST_W +: BURST_W] = bus.burst_i;
            end
          end
          // counter holds on the last beat so it never wraps
          if (cnt_q == LAST) state_d = FIN;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          if (cnt_q == LAST) state_d = FIN;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_o    = (state_q == READ);
  assign bus.write_o   = (state_q == WRITE);
  assign bus.address_o = addr_q;

  always_comb begin
    bus.burst_o = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (cnt_q == CW'(i)) begin
        bus.burst_o = wbuf_q[i*BURST_W +: BURST_W];
      end
    end
  end

`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
  always_comb begin
    bus.resp_o = (state_q != IDLE) && last_beat;
    bus.line_o = line_q;
    // final read beat bypasses the line register
    if (state_q == READ && last_beat) begin
      bus.line_o[LW-1 -: BURST_W] = bus.burst_i;
    end
  end
`else
  assign bus.resp_o = (state_q == DONE);
  assign bus.line_o = line_q;
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
// Works with or without CACHELINE_ADAPTER_EARLY_RESP_EN defined.
module tb_cacheline_adapter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  cacheline_adapter_if #(.BURST_W(64), .BURST_LEN(4)) bus ();

  cacheline_adapter #(
    .BURST_W   (64),
    .BURST_LEN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit           wr,
                      input bit           rd,
                      input logic [31:0]  addr,
                      input logic [255:0] wline,
                      input logic [255:0] beats,
                      input logic [15:0]  pat,
                      input logic [255:0] exp_line);
    int k;
    int i;
    logic [63:0] b;
    bus.write_i   = wr;
    bus.read_i    = rd;
    bus.address_i = addr;
    bus.line_i    = wline;
    @(negedge clk);
    check("addr_o", bus.address_o, {addr[31:5], 5'b0});
    check("read_o", bus.read_o, !wr);
    check("write_o", bus.write_o, wr);
    bus.address_i = 32'hdead_beef;
    bus.line_i    = ~wline;
    k = 0;
    i = 0;
    while (k < 4 && i < 16) begin
      b = beats[k*64 +: 64];
      bus.resp_i  = pat[i];
      bus.burst_i = b;
      #1;
      if (wr) check("burst_o", bus.burst_o, wline[k*64 +: 64]);
      check("busy", wr ? bus.write_o : bus.read_o, 1'b1);
      if (pat[i] && k == 3) begin
`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
        check("early_resp", bus.resp_o, 1'b1);
        if (!wr) check("fwd_beat", bus.line_o[255:192], b);
`else
        check("no_early_resp", bus.resp_o, 1'b0);
`endif
      end else begin
        check("no_resp", bus.resp_o, 1'b0);
      end
      if (pat[i]) k++;
      i++;
      @(negedge clk);
    end
    if (k < 4) check("beats_done", k, 4);
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    #1;
`ifdef CACHELINE_ADAPTER_EARLY_RESP_EN
    check("resp_after", bus.resp_o, 1'b0);
`else
    check("resp", bus.resp_o, 1'b1);
`endif
    check("read_off", bus.read_o, 1'b0);
    check("write_off", bus.write_o, 1'b0);
    check("line_o", bus.line_o, exp_line);
    @(negedge clk);
    #1;
    check("resp_one", bus.resp_o, 1'b0);
  endtask

  logic [255:0] l1, l2, l3, dw;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = {64'ha5a5_0003_0003_0003, 64'h5a5a_0002_0002_0002,
          64'hc3c3_0001_0001_0001, 64'h3c3c_0000_0000_0000};
    l3 = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
          64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0};
    dw = {64'hd3d3_d3d3_d3d3_d3d3, 64'hd2d2_d2d2_d2d2_d2d2,
          64'hd1d1_d1d1_d1d1_d1d1, 64'hd0d0_d0d0_d0d0_d0d0};
    rst           = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_read_o", bus.read_o, 1'b0);
    check("rst_write_o", bus.write_o, 1'b0);
    check("rst_resp_o", bus.resp_o, 1'b0);
    check("rst_addr_o", bus.address_o, 32'h0);
    check("rst_line_o", bus.line_o, 256'h0);
    check("rst_burst_o", bus.burst_o, 64'h0);
    rst = 1'b1;

    // consecutive read
    xfer(1'b0, 1'b1, 32'h0000_1234, '0, l1, 16'h000f, l1);
    check("addr_hold", bus.address_o, 32'h0000_1220);

    // write leaves line_o untouched
    xfer(1'b1, 1'b0, 32'h0000_8040, dw, '0, 16'h000f, l1);

    // stalled read: 1,0,0,1,0,1,1
    xfer(1'b0, 1'b1, 32'hffff_ffff, '0, l2, 16'h0069, l2);

    // read and write together: write wins
    xfer(1'b1, 1'b1, 32'h0000_0100, dw, '0, 16'h0069, l2);

    // resp_i while idle is ignored
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hbad0_bad0_bad0_bad0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_read_o", bus.read_o, 1'b0);
    check("idle_resp_o", bus.resp_o, 1'b0);
    check("idle_line_o", bus.line_o, l2);
    bus.resp_i = 1'b0;

    // reset after two beats of a read
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_4000;
    @(negedge clk);
    check("mid_read_o", bus.read_o, 1'b1);
    for (int j = 0; j < 2; j++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = l3[j*64 +: 64];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    rst        = 1'b0;
    #1;
    check("arst_read_o", bus.read_o, 1'b0);
    check("arst_resp_o", bus.resp_o, 1'b0);
    check("arst_line_o", bus.line_o, 256'h0);
    check("arst_addr_o", bus.address_o, 32'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("arst_no_resp", bus.resp_o, 1'b0);
    end
    rst = 1'b1;

    // next read completes normally
    xfer(1'b0, 1'b1, 32'h0000_4000, '0, l3, 16'h000f, l3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
